// File: rtl/iob_pcie_chnl_pkg.sv
// Shared types and helpers for the PCIe channel host: FSM encodings and beat-count arithmetic.
package iob_pcie_chnl_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_DATA = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_ACK  = 2'd1,
        T_DATA = 2'd2
    } tx_state_t;

    // 32-bit words carried per channel beat.
    function automatic int unsigned wpb(input int unsigned width);
        return width / 32;
    endfunction

    // WPB is always a power of two (1, 2 or 4), so division reduces to a shift.
    function automatic int unsigned wpb_log2(input int unsigned words);
        return (words >= 4) ? 2 : (words >= 2) ? 1 : 0;
    endfunction

    // Extra bit keeps LEN = 0xFFFFFFFF from wrapping to zero beats on wide channels.
    function automatic logic [32:0] ceil_beats(input logic [31:0] len, input int unsigned shift);
        logic [32:0] round_up;
        round_up = (33'd1 << shift) - 33'd1;
        return ({1'b0, len} + round_up) >> shift;
    endfunction

endpackage

// File: rtl/iob_pcie_chnl_oreg.sv
// One-entry valid/ready output register; accepts a new word whenever empty or being drained.
module iob_pcie_chnl_oreg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/iob_pcie_chnl_host.sv
// PCIe channel host: drives CHNL_RX transactions from a command/beat stream and drains CHNL_TX
// into a registered read stream. Optional idle-beat abort under macro IOB_PCIE_CHNL_TIMEOUT_EN.
module iob_pcie_chnl_host
    import iob_pcie_chnl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYC      = 1024
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        CMD_VALID,
    output logic                        CMD_READY,
    input  logic [31:0]                 CMD_LEN,
    input  logic [30:0]                 CMD_OFF,
    input  logic                        CMD_LAST,
    input  logic [C_PCI_DATA_WIDTH-1:0] WR_DATA,
    input  logic                        WR_VALID,
    output logic                        WR_READY,
    output logic                        CHNL_RX,
    output logic                        CHNL_RX_LAST,
    output logic                        CHNL_RX_DATA_VALID,
    output logic [31:0]                 CHNL_RX_LEN,
    output logic [30:0]                 CHNL_RX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_DATA_REN,
    input  logic                        CHNL_TX,
    input  logic                        CHNL_TX_LAST,
    input  logic                        CHNL_TX_DATA_VALID,
    input  logic [31:0]                 CHNL_TX_LEN,
    input  logic [30:0]                 CHNL_TX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_DATA_REN,
    output logic [C_PCI_DATA_WIDTH-1:0] RD_DATA,
    output logic                        RD_VALID,
    input  logic                        RD_READY,
    output logic [31:0]                 RD_LEN,
    output logic                        RD_DONE,
    output logic                        RX_TIMEOUT
);

    localparam int WPB        = wpb(C_PCI_DATA_WIDTH);
    localparam int BEAT_SHIFT = wpb_log2(WPB);

    // ---------------- RX direction ----------------
    rx_state_t   rx_state_reg, rx_state_next;
    logic [31:0] rx_len_reg;
    logic [30:0] rx_off_reg;
    logic        rx_last_reg;
    logic [32:0] rx_total_reg;
    logic [32:0] rx_cnt_reg;
    logic        rx_in_data;
    logic        cmd_fire;
    logic        rx_beat;
    logic        rx_final;
    logic        rx_abort;

    // Gated by RST_N so the command port stays quiet while the block is held in reset.
    assign CMD_READY  = (rx_state_reg == R_IDLE) && RST_N;
    assign cmd_fire   = CMD_VALID && CMD_READY;
    assign rx_in_data = (rx_state_reg == R_DATA);
    assign rx_beat    = rx_in_data && WR_VALID && CHNL_RX_DATA_REN;
    assign rx_final   = rx_beat && ((rx_cnt_reg + 33'd1) == rx_total_reg);

    assign CHNL_RX            = (rx_state_reg == R_REQ) || rx_in_data;
    assign CHNL_RX_LEN        = rx_len_reg;
    assign CHNL_RX_OFF        = rx_off_reg;
    assign CHNL_RX_LAST       = rx_last_reg;
    assign CHNL_RX_DATA_VALID = rx_in_data && WR_VALID;
    assign CHNL_RX_DATA       = rx_in_data ? WR_DATA : '0;
    assign WR_READY           = rx_in_data && CHNL_RX_DATA_REN;

`ifdef IOB_PCIE_CHNL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt_reg;

    assign rx_abort = rx_in_data && !rx_beat && (idle_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idle_cnt_reg <= '0;
        end else if (!rx_in_data || rx_beat || rx_abort) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign rx_abort = 1'b0;
`endif

    assign RX_TIMEOUT = rx_abort;

    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            R_IDLE: if (cmd_fire) rx_state_next = R_REQ;
            R_REQ: begin
                if (CHNL_RX_ACK) rx_state_next = (rx_total_reg == '0) ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_final || rx_abort) rx_state_next = R_IDLE;
            default: rx_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_state_reg <= R_IDLE;
            rx_len_reg   <= '0;
            rx_off_reg   <= '0;
            rx_last_reg  <= 1'b0;
            rx_total_reg <= '0;
            rx_cnt_reg   <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            if (cmd_fire) begin
                rx_len_reg   <= CMD_LEN;
                rx_off_reg   <= CMD_OFF;
                rx_last_reg  <= CMD_LAST;
                rx_total_reg <= ceil_beats(CMD_LEN, BEAT_SHIFT);
                rx_cnt_reg   <= '0;
            end else if (rx_beat) begin
                rx_cnt_reg <= rx_cnt_reg + 33'd1;
            end
        end
    end

    // ---------------- TX direction ----------------
    tx_state_t   tx_state_reg, tx_state_next;
    logic [31:0] rd_len_reg;
    logic [32:0] tx_total_reg;
    logic [32:0] tx_cnt_reg;
    logic        rd_done_reg;
    logic        oreg_in_ready;
    logic        tx_in_data;
    logic        tx_take;
    logic        tx_final;
    logic        tx_empty_done;
    logic        unused_tx_meta;

    assign unused_tx_meta = ^{CHNL_TX_LAST, CHNL_TX_OFF};

    assign tx_in_data       = (tx_state_reg == T_DATA);
    assign CHNL_TX_DATA_REN = tx_in_data && oreg_in_ready;
    assign tx_take          = CHNL_TX_DATA_REN && CHNL_TX_DATA_VALID;
    assign tx_final         = tx_take && ((tx_cnt_reg + 33'd1) == tx_total_reg);
    assign tx_empty_done    = (tx_state_reg == T_ACK) && (tx_total_reg == '0);
    assign CHNL_TX_ACK      = (tx_state_reg == T_ACK);
    assign RD_LEN           = rd_len_reg;
    assign RD_DONE          = rd_done_reg;

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            T_IDLE: if (CHNL_TX) tx_state_next = T_ACK;
            T_ACK:  tx_state_next = (tx_total_reg == '0) ? T_IDLE : T_DATA;
            T_DATA: if (tx_final) tx_state_next = T_IDLE;
            default: tx_state_next = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state_reg <= T_IDLE;
            rd_len_reg   <= '0;
            tx_total_reg <= '0;
            tx_cnt_reg   <= '0;
            rd_done_reg  <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            rd_done_reg  <= tx_final || tx_empty_done;
            if ((tx_state_reg == T_IDLE) && CHNL_TX) begin
                rd_len_reg   <= CHNL_TX_LEN;
                tx_total_reg <= ceil_beats(CHNL_TX_LEN, BEAT_SHIFT);
                tx_cnt_reg   <= '0;
            end else if (tx_take) begin
                tx_cnt_reg <= tx_cnt_reg + 33'd1;
            end
        end
    end

    iob_pcie_chnl_oreg #(
        .W(C_PCI_DATA_WIDTH)
    ) u_oreg (
        .clk      (CLK),
        .rst_n    (RST_N),
        .in_valid (tx_take),
        .in_data  (CHNL_TX_DATA),
        .in_ready (oreg_in_ready),
        .out_valid(RD_VALID),
        .out_data (RD_DATA),
        .out_ready(RD_READY)
    );

endmodule

// File: tb/tb_iob_pcie_chnl_host.sv
// Directed self-checking bench for iob_pcie_chnl_host: a 32-bit instance for RX/TX flows and a
// 64-bit instance for wide-beat rounding; covers IOB_PCIE_CHNL_TIMEOUT_EN when defined.
module tb_iob_pcie_chnl_host;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // 32-bit instance
    logic        cmd_valid = 0, cmd_ready, cmd_last = 0;
    logic [31:0] cmd_len = 0;
    logic [30:0] cmd_off = 0;
    logic [31:0] wr_data = 0;
    logic        wr_valid = 0, wr_ready;
    logic        chnl_rx, chnl_rx_last, chnl_rx_data_valid;
    logic [31:0] chnl_rx_len;
    logic [30:0] chnl_rx_off;
    logic [31:0] chnl_rx_data;
    logic        chnl_rx_ack = 0, chnl_rx_data_ren = 0;
    logic        chnl_tx = 0, chnl_tx_last = 0, chnl_tx_data_valid = 0;
    logic [31:0] chnl_tx_len = 0;
    logic [30:0] chnl_tx_off = 0;
    logic [31:0] chnl_tx_data = 0;
    logic        chnl_tx_ack, chnl_tx_data_ren;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready = 0;
    logic [31:0] rd_len;
    logic        rd_done, rx_timeout;

    // 64-bit instance
    logic        w64_cmd_valid = 0, w64_cmd_ready;
    logic [31:0] w64_cmd_len = 0;
    logic [63:0] w64_wr_data = 0;
    logic        w64_wr_valid = 0, w64_wr_ready;
    logic        w64_chnl_rx, w64_chnl_rx_last, w64_chnl_rx_data_valid;
    logic [31:0] w64_chnl_rx_len;
    logic [30:0] w64_chnl_rx_off;
    logic [63:0] w64_chnl_rx_data;
    logic        w64_chnl_rx_ack = 0, w64_chnl_rx_data_ren = 0;
    logic        w64_chnl_tx = 0, w64_chnl_tx_data_valid = 0;
    logic [31:0] w64_chnl_tx_len = 0;
    logic [63:0] w64_chnl_tx_data = 0;
    logic        w64_chnl_tx_ack, w64_chnl_tx_data_ren;
    logic [63:0] w64_rd_data;
    logic        w64_rd_valid, w64_rd_ready = 0;
    logic [31:0] w64_rd_len;
    logic        w64_rd_done, w64_rx_timeout;

    iob_pcie_chnl_host #(.C_PCI_DATA_WIDTH(32), .TIMEOUT_CYC(16)) dut32 (
        .CLK(clk), .RST_N(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_LEN(cmd_len), .CMD_OFF(cmd_off),
        .CMD_LAST(cmd_last), .WR_DATA(wr_data), .WR_VALID(wr_valid), .WR_READY(wr_ready),
        .CHNL_RX(chnl_rx), .CHNL_RX_LAST(chnl_rx_last), .CHNL_RX_DATA_VALID(chnl_rx_data_valid),
        .CHNL_RX_LEN(chnl_rx_len), .CHNL_RX_OFF(chnl_rx_off), .CHNL_RX_DATA(chnl_rx_data),
        .CHNL_RX_ACK(chnl_rx_ack), .CHNL_RX_DATA_REN(chnl_rx_data_ren),
        .CHNL_TX(chnl_tx), .CHNL_TX_LAST(chnl_tx_last), .CHNL_TX_DATA_VALID(chnl_tx_data_valid),
        .CHNL_TX_LEN(chnl_tx_len), .CHNL_TX_OFF(chnl_tx_off), .CHNL_TX_DATA(chnl_tx_data),
        .CHNL_TX_ACK(chnl_tx_ack), .CHNL_TX_DATA_REN(chnl_tx_data_ren),
        .RD_DATA(rd_data), .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_LEN(rd_len),
        .RD_DONE(rd_done), .RX_TIMEOUT(rx_timeout)
    );

    iob_pcie_chnl_host #(.C_PCI_DATA_WIDTH(64), .TIMEOUT_CYC(1024)) dut64 (
        .CLK(clk), .RST_N(rst_n),
        .CMD_VALID(w64_cmd_valid), .CMD_READY(w64_cmd_ready), .CMD_LEN(w64_cmd_len),
        .CMD_OFF(31'd0), .CMD_LAST(1'b0), .WR_DATA(w64_wr_data), .WR_VALID(w64_wr_valid),
        .WR_READY(w64_wr_ready), .CHNL_RX(w64_chnl_rx), .CHNL_RX_LAST(w64_chnl_rx_last),
        .CHNL_RX_DATA_VALID(w64_chnl_rx_data_valid), .CHNL_RX_LEN(w64_chnl_rx_len),
        .CHNL_RX_OFF(w64_chnl_rx_off), .CHNL_RX_DATA(w64_chnl_rx_data),
        .CHNL_RX_ACK(w64_chnl_rx_ack), .CHNL_RX_DATA_REN(w64_chnl_rx_data_ren),
        .CHNL_TX(w64_chnl_tx), .CHNL_TX_LAST(1'b0), .CHNL_TX_DATA_VALID(w64_chnl_tx_data_valid),
        .CHNL_TX_LEN(w64_chnl_tx_len), .CHNL_TX_OFF(31'd0), .CHNL_TX_DATA(w64_chnl_tx_data),
        .CHNL_TX_ACK(w64_chnl_tx_ack), .CHNL_TX_DATA_REN(w64_chnl_tx_data_ren),
        .RD_DATA(w64_rd_data), .RD_VALID(w64_rd_valid), .RD_READY(w64_rd_ready),
        .RD_LEN(w64_rd_len), .RD_DONE(w64_rd_done), .RX_TIMEOUT(w64_rx_timeout)
    );

    task automatic issue_cmd32(input logic [31:0] len, input logic [30:0] off, input logic last);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_len = len; cmd_off = off; cmd_last = last;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic start_tx32(input logic [31:0] len);
        @(posedge clk); #1;
        chnl_tx = 1'b1; chnl_tx_len = len;
        @(posedge clk); #1;
        chnl_tx = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        chnl_rx_ack = 0; wr_valid = 0; chnl_rx_data_ren = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({chnl_rx, chnl_rx_data_valid, wr_ready, chnl_tx_ack, chnl_tx_data_ren, rd_valid, rd_done, rx_timeout} !== 8'h00)
            $display("FAIL reset_ctrl: got %b required 00000000", {chnl_rx, chnl_rx_data_valid, wr_ready, chnl_tx_ack, chnl_tx_data_ren, rd_valid, rd_done, rx_timeout});
        else passed++;
        total++; if (rd_len !== 32'h0 || rd_data !== 32'h0 || chnl_rx_len !== 32'h0)
            $display("FAIL reset_data: rd_len %0h rd_data %0h rx_len %0h required 0", rd_len, rd_data, chnl_rx_len);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b1 || w64_cmd_ready !== 1'b1)
            $display("FAIL reset_cmd_ready: got %b/%b required 1/1", cmd_ready, w64_cmd_ready);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_rx_basic();
        int rx_cycles = 0;
        int beats = 0;
        logic ready_at7 = 1'b0;
        logic rx_at7 = 1'b1;
        issue_cmd32(32'd4, 31'h12, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chnl_rx_ack = (i == 2);
            chnl_rx_data_ren = 1'b1;
            wr_valid = 1'b1;
            wr_data = 32'hA000 + beats;
            #1;
            if (i == 0) begin
                total++; if (chnl_rx_len !== 32'd4 || chnl_rx_off !== 31'h12 || chnl_rx_last !== 1'b1)
                    $display("FAIL rx_latched: len %0h off %0h last %b required 4 12 1", chnl_rx_len, chnl_rx_off, chnl_rx_last);
                else passed++;
                total++; if (wr_ready !== 1'b0 || cmd_ready !== 1'b0)
                    $display("FAIL rx_req_ready: wr_ready %b cmd_ready %b required 0 0", wr_ready, cmd_ready);
                else passed++;
            end
            if (i == 7) begin
                ready_at7 = cmd_ready;
                rx_at7 = chnl_rx;
            end
            if (chnl_rx) rx_cycles++;
            if (chnl_rx_data_valid && chnl_rx_data_ren) begin
                total++; if (chnl_rx_data !== 32'hA000 + beats || wr_ready !== 1'b1)
                    $display("FAIL rx_beat%0d: data %0h wr_ready %b required %0h 1", beats, chnl_rx_data, wr_ready, 32'hA000 + beats);
                else passed++;
                beats++;
            end
            @(posedge clk); #1;
        end
        chnl_rx_ack = 0; wr_valid = 0; chnl_rx_data_ren = 0;
        total++; if (rx_cycles != 7) $display("FAIL rx_high_cycles: got %0d required 7", rx_cycles); else passed++;
        total++; if (beats != 4) $display("FAIL rx_beat_count: got %0d required 4", beats); else passed++;
        total++; if (ready_at7 !== 1'b1 || rx_at7 !== 1'b0)
            $display("FAIL rx_return_idle: cmd_ready %b chnl_rx %b required 1 0", ready_at7, rx_at7);
        else passed++;
        $display("test_rx_basic done: %0d beats in %0d cycles", beats, rx_cycles);
    endtask

    task automatic test_rx_zero();
        int rx_cycles = 0;
        int beats = 0;
        logic ready_at2 = 1'b0;
        issue_cmd32(32'd0, 31'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chnl_rx_ack = (i == 1);
            chnl_rx_data_ren = 1'b1;
            wr_valid = 1'b1;
            #1;
            if (i == 2) ready_at2 = cmd_ready;
            if (chnl_rx) rx_cycles++;
            if (chnl_rx_data_valid) beats++;
            @(posedge clk); #1;
        end
        chnl_rx_ack = 0; wr_valid = 0; chnl_rx_data_ren = 0;
        total++; if (rx_cycles != 2) $display("FAIL rx0_high_cycles: got %0d required 2", rx_cycles); else passed++;
        total++; if (beats != 0) $display("FAIL rx0_beats: got %0d required 0", beats); else passed++;
        total++; if (ready_at2 !== 1'b1) $display("FAIL rx0_idle: cmd_ready %b required 1", ready_at2); else passed++;
        $display("test_rx_zero done");
    endtask

    // Max length on a 64-bit channel must still yield a nonzero beat count.
    task automatic test_len_max();
        @(posedge clk); #1;
        w64_cmd_valid = 1'b1; w64_cmd_len = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        w64_cmd_valid = 1'b0; w64_chnl_rx_ack = 1'b1;
        @(posedge clk); #1;
        w64_chnl_rx_ack = 1'b0; w64_wr_valid = 1'b1; w64_chnl_rx_data_ren = 1'b0;
        #1;
        total++; if (w64_chnl_rx !== 1'b1 || w64_chnl_rx_data_valid !== 1'b1 || w64_wr_ready !== 1'b0)
            $display("FAIL len_max_data: rx %b valid %b wr_ready %b required 1 1 0", w64_chnl_rx, w64_chnl_rx_data_valid, w64_wr_ready);
        else passed++;
        $display("test_len_max done");
    endtask

    task automatic test_tx_wide();
        int takes = 0, acks = 0, dones = 0, drained = 0;
        @(posedge clk); #1;
        w64_chnl_tx = 1'b1; w64_chnl_tx_len = 32'd5; w64_rd_ready = 1'b1; w64_chnl_tx_data_valid = 1'b1;
        @(posedge clk); #1;
        w64_chnl_tx = 1'b0;
        for (int i = 0; i < 12; i++) begin
            w64_chnl_tx_data = {32'hC0DE_0000, 32'(takes)};
            #1;
            if (w64_chnl_tx_ack) acks++;
            if (w64_rd_done) dones++;
            if (w64_chnl_tx_data_valid && w64_chnl_tx_data_ren) takes++;
            if (w64_rd_valid && w64_rd_ready) begin
                total++; if (w64_rd_data !== {32'hC0DE_0000, 32'(drained)})
                    $display("FAIL tx64_beat%0d: got %0h required %0h", drained, w64_rd_data, {32'hC0DE_0000, 32'(drained)});
                else passed++;
                drained++;
            end
            @(posedge clk); #1;
        end
        w64_chnl_tx_data_valid = 1'b0;
        total++; if (takes != 3 || drained != 3) $display("FAIL tx64_beats: taken %0d drained %0d required 3 3", takes, drained); else passed++;
        total++; if (w64_rd_len !== 32'd5) $display("FAIL tx64_rd_len: got %0d required 5", w64_rd_len); else passed++;
        total++; if (acks != 1 || dones != 1) $display("FAIL tx64_pulses: ack %0d done %0d required 1 1", acks, dones); else passed++;
        $display("test_tx_wide done: %0d beats", takes);
    endtask

    task automatic test_mid_reset();
        int beats = 0;
        issue_cmd32(32'd4, 31'h5, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chnl_rx_ack = (i == 0);
            chnl_rx_data_ren = 1'b1;
            wr_valid = 1'b1;
            wr_data = 32'h7000 + beats;
            #1;
            if (chnl_rx_data_valid && chnl_rx_data_ren) beats++;
            if (beats == 2) break;
            @(posedge clk); #1;
        end
        total++; if (beats != 2) $display("FAIL mreset_prefix: got %0d beats required 2", beats); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({chnl_rx, chnl_rx_data_valid, wr_ready, rx_timeout, w64_chnl_rx, w64_chnl_rx_data_valid} !== 6'b0)
            $display("FAIL mreset_outputs: got %b required 000000", {chnl_rx, chnl_rx_data_valid, wr_ready, rx_timeout, w64_chnl_rx, w64_chnl_rx_data_valid});
        else passed++;
        total++; if (chnl_rx_len !== 32'h0 || chnl_rx_data !== 32'h0 || w64_rd_len !== 32'h0)
            $display("FAIL mreset_data: rx_len %0h rx_data %0h rd_len64 %0h required 0", chnl_rx_len, chnl_rx_data, w64_rd_len);
        else passed++;
        chnl_rx_ack = 0; wr_valid = 0; chnl_rx_data_ren = 0;
        w64_wr_valid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b1 || chnl_rx !== 1'b0)
            $display("FAIL mreset_release: cmd_ready %b chnl_rx %b required 1 0", cmd_ready, chnl_rx);
        else passed++;
        $display("test_mid_reset done");
    endtask

    task automatic test_back_to_back();
        int takes = 0, drained = 0, first_take = -1, last_take = -1, done_idx = -1;
        rd_ready = 1'b1; chnl_tx_data_valid = 1'b1;
        start_tx32(32'd4);
        for (int i = 0; i < 10; i++) begin
            chnl_tx_data = 32'h5000 + takes;
            #1;
            if (i == 0) begin
                total++; if (chnl_tx_ack !== 1'b1 || chnl_tx_data_ren !== 1'b0)
                    $display("FAIL b2b_ack: ack %b ren %b required 1 0", chnl_tx_ack, chnl_tx_data_ren);
                else passed++;
            end
            if (chnl_tx_data_valid && chnl_tx_data_ren) begin
                if (first_take < 0) first_take = i;
                last_take = i;
                takes++;
            end
            if (rd_done) done_idx = i;
            if (rd_valid && rd_ready) begin
                total++; if (rd_data !== 32'h5000 + drained)
                    $display("FAIL b2b_beat%0d: got %0h required %0h", drained, rd_data, 32'h5000 + drained);
                else passed++;
                drained++;
            end
            @(posedge clk); #1;
        end
        chnl_tx_data_valid = 1'b0;
        total++; if (first_take != 1 || last_take != 4 || takes != 4)
            $display("FAIL b2b_rate: first %0d last %0d takes %0d required 1 4 4", first_take, last_take, takes);
        else passed++;
        total++; if (done_idx != 5 || drained != 4)
            $display("FAIL b2b_done: done at %0d drained %0d required 5 4", done_idx, drained);
        else passed++;
        $display("test_back_to_back done");
    endtask

    task automatic test_tx_backpressure();
        int takes = 0, drained = 0, dones = 0, ren_bad = 0;
        logic ack_seen = 1'b0;
        chnl_tx_data_valid = 1'b1;
        start_tx32(32'd8);
        for (int i = 0; i < 40; i++) begin
            rd_ready = (i % 2 == 0);
            chnl_tx_data = 32'h6000 + takes;
            #1;
            if (ack_seen && takes < 8 && !chnl_tx_data_ren && !(rd_valid && !rd_ready)) ren_bad++;
            if (chnl_tx_ack) ack_seen = 1'b1;
            if (rd_done) dones++;
            if (chnl_tx_data_valid && chnl_tx_data_ren) takes++;
            if (rd_valid && rd_ready) begin
                total++; if (rd_data !== 32'h6000 + drained)
                    $display("FAIL bp_beat%0d: got %0h required %0h", drained, rd_data, 32'h6000 + drained);
                else passed++;
                drained++;
            end
            @(posedge clk); #1;
        end
        chnl_tx_data_valid = 1'b0; rd_ready = 1'b0;
        total++; if (takes != 8 || drained != 8) $display("FAIL bp_count: taken %0d drained %0d required 8 8", takes, drained); else passed++;
        total++; if (ren_bad != 0) $display("FAIL bp_ren_low: %0d unexpected stall cycles required 0", ren_bad); else passed++;
        total++; if (dones != 1 || rd_len !== 32'd8) $display("FAIL bp_done: pulses %0d rd_len %0d required 1 8", dones, rd_len); else passed++;
        $display("test_tx_backpressure done");
    endtask

    task automatic test_timeout();
        int pulses = 0, pulse_idx = -1;
        logic rx_at17 = 1'bx;
        issue_cmd32(32'd4, 31'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chnl_rx_ack = (i == 0);
            chnl_rx_data_ren = 1'b1;
            wr_valid = 1'b0;
            #1;
            if (rx_timeout) begin pulses++; pulse_idx = i; end
            if (i == 17) rx_at17 = chnl_rx;
            @(posedge clk); #1;
        end
        chnl_rx_ack = 0; chnl_rx_data_ren = 0;
`ifdef IOB_PCIE_CHNL_TIMEOUT_EN
        total++; if (pulses != 1 || pulse_idx != 16)
            $display("FAIL timeout_pulse: %0d pulses at %0d required 1 at 16", pulses, pulse_idx);
        else passed++;
        total++; if (rx_at17 !== 1'b0) $display("FAIL timeout_abort: chnl_rx %b required 0", rx_at17); else passed++;
`else
        total++; if (pulses != 0) $display("FAIL timeout_tied: %0d pulses required 0", pulses); else passed++;
        total++; if (rx_at17 !== 1'b1) $display("FAIL timeout_hold: chnl_rx %b required 1", rx_at17); else passed++;
        apply_reset();
`endif
        $display("test_timeout done");
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_rx_zero();
        test_len_max();
        test_tx_wide();
        test_mid_reset();
        test_back_to_back();
        test_tx_backpressure();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/iob_pcie_chnl_host.md
IOB_PCIE_CHNL_HOST -- requirements
Module: iob_pcie_chnl_host

Interface
REQ-001 SHALL have parameter C_PCI_DATA_WIDTH, default 32, channel data width in bits (32, 64 or 128); WPB = C_PCI_DATA_WIDTH/32 words per beat.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, idle-beat limit in cycles (used only under IOB_PCIE_CHNL_TIMEOUT_EN).
REQ-003 SHALL have ports:
- CLK  in  1  sole clock; all logic on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  request to send one RX transaction.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY.
- CMD_LEN  in  32  transaction length in 32-bit words.
- CMD_OFF  in  31  transaction offset.
- CMD_LAST  in  1  last-transaction flag.
- WR_DATA  in  C_PCI_DATA_WIDTH  outbound payload beat.
- WR_VALID  in  1  WR_DATA valid.
- WR_READY  out  1  beat consumed when WR_VALID & WR_READY.
- CHNL_RX / CHNL_RX_LAST / CHNL_RX_DATA_VALID  out  1  RX channel controls toward user core.
- CHNL_RX_LEN  out  32;  CHNL_RX_OFF  out  31;  CHNL_RX_DATA  out  C_PCI_DATA_WIDTH.
- CHNL_RX_ACK / CHNL_RX_DATA_REN  in  1  user core acknowledge / read enable.
- CHNL_TX / CHNL_TX_LAST / CHNL_TX_DATA_VALID  in  1;  CHNL_TX_LEN  in  32;  CHNL_TX_OFF  in  31;  CHNL_TX_DATA  in  C_PCI_DATA_WIDTH.
- CHNL_TX_ACK / CHNL_TX_DATA_REN  out  1.
- RD_DATA  out  C_PCI_DATA_WIDTH  inbound beat;  RD_VALID  out  1;  RD_READY  in  1.
- RD_LEN  out  32  latched CHNL_TX_LEN of current/last TX transaction.
- RD_DONE  out  1  one-cycle pulse at end of TX transaction.
- RX_TIMEOUT  out  1  one-cycle abort pulse (tied 0 without macro).

Function
REQ-004 Beat count SHALL be ceil(LEN/WPB), computed in 33-bit arithmetic so LEN=0xFFFFFFFF does not wrap.
REQ-005 RX FSM states SHALL be R_IDLE, R_REQ, R_DATA.
REQ-006 R_IDLE: CMD_READY=1; on handshake latch LEN/OFF/LAST, clear beat counter, go R_REQ next cycle.
REQ-007 R_REQ and R_DATA: CHNL_RX=1, CHNL_RX_LEN/OFF/LAST driven from latched values, stable until return to R_IDLE.
REQ-008 R_REQ: on CHNL_RX_ACK go R_DATA; if latched beat count is 0, go R_IDLE instead.
REQ-009 R_DATA: CHNL_RX_DATA_VALID=WR_VALID, CHNL_RX_DATA=WR_DATA, WR_READY=CHNL_RX_DATA_REN (combinational pass-through, zero latency); count beats where WR_VALID & CHNL_RX_DATA_REN.
REQ-010 Cycle final beat is accepted SHALL transition to R_IDLE; CHNL_RX low the following cycle; CMD_READY high again that cycle.
REQ-011 WR_READY, CHNL_RX_DATA_VALID SHALL be 0 outside R_DATA.
REQ-012 TX FSM states SHALL be T_IDLE, T_ACK, T_DATA, independent of RX FSM (both directions may run concurrently).
REQ-013 T_IDLE: on CHNL_TX=1 latch CHNL_TX_LEN into RD_LEN, go T_ACK; CHNL_TX_ACK=1 for exactly one cycle in T_ACK.
REQ-014 T_ACK: go T_DATA; if beat count 0, go T_IDLE and pulse RD_DONE.
REQ-015 T_DATA: one-entry output register; CHNL_TX_DATA_REN = !RD_VALID | RD_READY; beat taken when CHNL_TX_DATA_VALID & CHNL_TX_DATA_REN, loaded into RD_DATA with RD_VALID=1 next cycle (latency 1).
REQ-016 On final beat taken SHALL go T_IDLE and pulse RD_DONE next cycle; pending RD_VALID beat SHALL still drain; CHNL_TX_DATA_REN=0 outside T_DATA.
REQ-017 Simultaneous take and drain in T_DATA SHALL sustain one beat per cycle without loss or duplication.

Reset
REQ-018 RST_N low SHALL asynchronously force R_IDLE, T_IDLE, counters 0, all outputs 0 except CMD_READY (1 after reset release), RD_LEN 0, RD_DATA 0; mid-transaction reset discards the transaction.

Configuration
REQ-019 With IOB_PCIE_CHNL_TIMEOUT_EN defined, R_DATA SHALL count consecutive cycles without an accepted beat; reaching TIMEOUT_CYC SHALL pulse RX_TIMEOUT and return to R_IDLE; without it, no counter exists and RX_TIMEOUT=0.

Structure
REQ-020 Shared package iob_pcie_chnl_pkg SHALL hold RX/TX state encodings, WPB computation, and ceil-beat function.
REQ-021 TX output register SHALL be sub-module iob_pcie_chnl_oreg (one-entry valid/ready register).

Verification
REQ-022 CMD_LEN=4, WPB=1, ACK after 2 cycles, REN always 1 -> CHNL_RX high 1+2+4 cycles, exactly 4 beats, CMD_READY back after last beat.
REQ-023 CMD_LEN=0 -> one CHNL_RX request, ACK, zero data beats, return to R_IDLE.
REQ-024 C_PCI_DATA_WIDTH=64, CHNL_TX_LEN=5 -> 3 beats accepted, RD_LEN=5, RD_DONE single pulse.
REQ-025 TX 8 beats with RD_READY toggling 1/0 -> RD_DATA order preserved, no beat lost, CHNL_TX_DATA_REN low only when register full and RD_READY=0.
REQ-026 RST_N asserted mid R_DATA after 2 of 4 beats -> all outputs 0 immediately, CMD_READY=1 after release.
REQ-027 With IOB_PCIE_CHNL_TIMEOUT_EN, TIMEOUT_CYC=16, WR_VALID held 0 in R_DATA -> RX_TIMEOUT pulse at cycle 16, CHNL_RX low next cycle.
